nn_mac_layer: RTL

//  Parametrised fully-connected neural-network layer: NUM_NEURONS parallel MAC lanes consume one

---
 rtl/nn_pkg.sv | 33 +++
 rtl/nn_mac_lane.sv | 94 +++++++++
 rtl/nn_mac_layer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared types and helpers for the fully-connected MAC layer.
// Holds the layer FSM states, activation encoding and the signed saturation helper.
package nn_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StAccum,
      StFinish,
      StOut
   } state_e;

   typedef enum logic {
      ActLinear,
      ActRelu
   } act_mode_e;

   // Clamp a wide signed value into the range of an out_w-bit signed number.
   function automatic logic signed [63:0] sat_signed(input logic signed [63:0] val,
                                                     input int unsigned        out_w);
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (out_w - 1));
      if (val > max_v) begin
         return max_v;
      end
      if (val < min_v) begin
         return min_v;
      end
      return val;
   endfunction

endpackage

// File: rtl/nn_mac_lane.sv
// One neuron lane: weight/bias storage, MAC accumulator and the bias/shift/ReLU/saturate stage.
// All strobes arrive already qualified by clk_en and the layer FSM.
module nn_mac_lane
   import nn_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned FRAC_BITS = 4,
   parameter int unsigned N_INPUTS  = 4,
   parameter int unsigned OUT_W     = 8,
   parameter int unsigned IDX_W     = 3
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     w_we_i,
   input  logic [IDX_W-1:0]         w_idx_i,
   input  logic signed [DATA_W-1:0] w_data_i,
   input  logic                     acc_load_i,
   input  logic                     acc_add_i,
   input  logic [IDX_W-1:0]         mac_idx_i,
   input  logic signed [DATA_W-1:0] in_data_i,
   input  logic                     finish_i,
   input  logic                     relu_i,
   output logic [OUT_W-1:0]         out_data_o
);

   localparam int unsigned ACC_W     = 2 * DATA_W + $clog2(N_INPUTS) + 1;
   localparam int unsigned PROD_W    = 2 * DATA_W;
   localparam int unsigned NUM_SLOTS = 1 << IDX_W;

   logic signed [DATA_W-1:0] w_q [NUM_SLOTS];
   logic signed [DATA_W-1:0] w_sel;
   logic signed [DATA_W-1:0] bias;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  acc_d;
   logic signed [ACC_W-1:0]  acc_q;
   logic signed [63:0]       acc_wide;
   logic signed [63:0]       bias_wide;
   logic signed [63:0]       res_wide;
   logic signed [63:0]       res_act;
   logic [OUT_W-1:0]         out_d;
   logic [OUT_W-1:0]         out_q;

   // Slot N_INPUTS holds the bias; slots above it are never written.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            w_q[i] <= '0;
         end
      end else if (w_we_i) begin
         w_q[w_idx_i] <= w_data_i;
      end
   end

   assign w_sel    = w_q[mac_idx_i];
   assign bias     = w_q[IDX_W'(N_INPUTS)];
   assign prod     = in_data_i * w_sel;
   assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

   always_comb begin
      acc_d = acc_q;
      if (acc_load_i) begin
         acc_d = prod_ext;
      end else if (acc_add_i) begin
         acc_d = acc_q + prod_ext;
      end
   end

   // Bias is aligned to the product's Q format before the final arithmetic shift.
   assign acc_wide  = {{(64 - ACC_W){acc_q[ACC_W-1]}}, acc_q};
   assign bias_wide = {{(64 - DATA_W){bias[DATA_W-1]}}, bias};
   assign res_wide  = (acc_wide + (bias_wide <<< FRAC_BITS)) >>> FRAC_BITS;
   assign res_act   = (relu_i && (res_wide < 64'sd0)) ? 64'sd0 : res_wide;

   always_comb begin
      out_d = out_q;
      if (finish_i) begin
         out_d = OUT_W'(sat_signed(res_act, OUT_W));
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_q <= '0;
         out_q <= '0;
      end else begin
         acc_q <= acc_d;
         out_q <= out_d;
      end
   end

   assign out_data_o = out_q;

endmodule

// File: rtl/nn_mac_layer.sv
// Fully-connected layer: NUM_NEURONS MAC lanes fed element-serially from one input stream.
// This level owns the FSM, element index, stream handshakes and weight-write error pulse.
module nn_mac_layer
   import nn_pkg::*;
#(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned FRAC_BITS   = 4,
   parameter int unsigned N_INPUTS    = 4,
   parameter int unsigned NUM_NEURONS = 2,
   parameter int unsigned OUT_W       = 8,
   localparam int unsigned IDX_W      = $clog2(N_INPUTS + 1),
   localparam int unsigned NEURON_W   = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           clk_en_i,
   input  logic                           w_we_i,
   input  logic [NEURON_W-1:0]            w_neuron_i,
   input  logic [IDX_W-1:0]               w_idx_i,
   input  logic signed [DATA_W-1:0]       w_data_i,
   output logic                           w_err_o,
   input  logic                           act_mode_i,
   input  logic                           in_valid_i,
   output logic                           in_ready_o,
   input  logic signed [DATA_W-1:0]       in_data_i,
   output logic                           out_valid_o,
   input  logic                           out_ready_i,
   output logic [NUM_NEURONS*OUT_W-1:0]   out_data_o,
   output logic                           busy_o
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);
   localparam logic [IDX_W-1:0] BIAS_IDX = IDX_W'(N_INPUTS);

   state_e           state_q;
   logic [IDX_W-1:0] idx_q;
   logic             out_valid_q;
   logic             w_err_q;

   logic             accept;
   logic             wr_ok;
   logic             acc_load;
   logic             acc_add;
   logic             finish;
   logic             relu;
   logic [IDX_W-1:0] mac_idx;

   assign in_ready_o = clk_en_i & ((state_q == StIdle) | (state_q == StAccum));
   assign accept     = in_valid_i & in_ready_o;

   // An element accepted in IDLE takes priority over a weight write in the same cycle.
   assign wr_ok = w_we_i & clk_en_i & (state_q == StIdle) & (w_idx_i <= BIAS_IDX) & ~accept;

   assign acc_load = accept & (state_q == StIdle);
   assign acc_add  = accept & (state_q == StAccum);
   assign finish   = clk_en_i & (state_q == StFinish);
   assign relu     = (act_mode_e'(act_mode_i) == ActRelu);
   assign mac_idx  = (state_q == StIdle) ? '0 : idx_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         idx_q       <= '0;
         out_valid_q <= 1'b0;
         w_err_q     <= 1'b0;
      end else begin
         w_err_q <= clk_en_i & w_we_i & ~wr_ok;
         if (clk_en_i) begin
            case (state_q)
               StIdle: begin
                  if (accept) begin
                     idx_q   <= IDX_W'(1);
                     state_q <= (N_INPUTS == 1) ? StFinish : StAccum;
                  end
               end
               StAccum: begin
                  if (accept) begin
                     idx_q <= idx_q + IDX_W'(1);
                     if (idx_q == LAST_IDX) begin
                        state_q <= StFinish;
                     end
                  end
               end
               StFinish: begin
                  idx_q       <= '0;
                  out_valid_q <= 1'b1;
                  state_q     <= StOut;
               end
               StOut: begin
                  if (out_ready_i) begin
                     out_valid_q <= 1'b0;
                     state_q     <= StIdle;
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   for (genvar n = 0; n < int'(NUM_NEURONS); n++) begin : g_lane
      logic lane_we;
      assign lane_we = wr_ok & (w_neuron_i == NEURON_W'(n));

      nn_mac_lane #(
         .DATA_W    (DATA_W),
         .FRAC_BITS (FRAC_BITS),
         .N_INPUTS  (N_INPUTS),
         .OUT_W     (OUT_W),
         .IDX_W     (IDX_W)
      ) u_lane (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .w_we_i     (lane_we),
         .w_idx_i    (w_idx_i),
         .w_data_i   (w_data_i),
         .acc_load_i (acc_load),
         .acc_add_i  (acc_add),
         .mac_idx_i  (mac_idx),
         .in_data_i  (in_data_i),
         .finish_i   (finish),
         .relu_i     (relu),
         .out_data_o (out_data_o[n*OUT_W +: OUT_W])
      );
   end

   assign out_valid_o = out_valid_q;
   assign w_err_o     = w_err_q;
   assign busy_o      = (state_q != StIdle);

endmodule
